// File: rtl/t2mi_byte_packer.sv
// Serial byte -> DATA_WIDTH word packer feeding the parallel T2MI parser; in_sop realigns so 0x47 lands in lane 0.
// Optional live statistics counters are built when T2MI_PACKER_STATS_EN is defined.

module t2mi_packer_lane #(
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  clr,
  input  logic [BYTE_WIDTH-1:0] din,
  output logic [BYTE_WIDTH-1:0] q,
  output logic                  v
);
  // A write wins over clear so a realign can empty the word and seed lane 0 in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      v <= 1'b0;
    end else if (wr) begin
      q <= din;
      v <= 1'b1;
    end else if (clr) begin
      q <= '0;
      v <= 1'b0;
    end
  end
endmodule

module t2mi_byte_packer #(
  parameter int DATA_WIDTH   = 64,
  parameter int BYTE_WIDTH   = 8,
  parameter int NUM_BYTES    = DATA_WIDTH / BYTE_WIDTH,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [BYTE_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_BYTES-1:0]  out_byte_enable,
  output logic [31:0]           words_out,
  output logic [31:0]           partial_words,
  output logic [31:0]           bytes_in
);
  localparam int              LW      = $clog2(NUM_BYTES);
  localparam logic [LW-1:0]   LAST    = LW'(NUM_BYTES - 1);
  localparam bit              TO_EN   = (IDLE_TIMEOUT != 0);
  localparam logic [15:0]     TO_LAST = TO_EN ? 16'(IDLE_TIMEOUT - 1) : 16'd0;

  typedef struct packed {
    logic                  vld;
    logic [DATA_WIDTH-1:0] data;
    logic [NUM_BYTES-1:0]  be;
  } word_t;

  logic [LW-1:0]                        lane_idx, lane_idx_n;
  logic [15:0]                          idle_cnt, idle_cnt_n;
  logic                                 pend, pend_n;
  logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] lane_q, cur_data;
  logic [NUM_BYTES-1:0]                 lane_v, cur_mask, lane_wr;
  logic                                 clr_all, store, realign, last_lane, expire;
  word_t                                emit, out_q;

  assign in_ready  = !pend;
  assign store     = in_valid && !pend;
  assign realign   = store && in_sop && (lane_idx != '0);
  assign last_lane = (lane_idx == LAST);
  assign expire    = TO_EN && (lane_idx != '0) && (idle_cnt == TO_LAST);

  genvar k;
  generate
    for (k = 0; k < NUM_BYTES; k++) begin : g_lane
      t2mi_packer_lane #(.BYTE_WIDTH(BYTE_WIDTH)) u_lane (
        .clk (clk),
        .rst (rst),
        .wr  (lane_wr[k]),
        .clr (clr_all),
        .din (in_data),
        .q   (lane_q[k]),
        .v   (lane_v[k])
      );
    end
  endgenerate

  // Accumulator as it would look with this cycle's byte merged in (used when it emits at once).
  always_comb begin
    cur_data = lane_q;
    cur_mask = lane_v;
    if (store && !realign) begin
      cur_data[lane_idx] = in_data;
      cur_mask[lane_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_idx <= '0;
      idle_cnt <= '0;
      pend     <= 1'b0;
    end else begin
      lane_idx <= lane_idx_n;
      idle_cnt <= idle_cnt_n;
      pend     <= pend_n;
    end
  end

  always_comb begin
    lane_idx_n = lane_idx;
    pend_n     = 1'b0;
    if (pend)
      lane_idx_n = '0;
    else if (realign) begin
      lane_idx_n = LW'(1);
      pend_n     = flush;
    end else if (store)
      lane_idx_n = (last_lane || flush) ? '0 : lane_idx + 1'b1;
    else if (flush || expire)
      lane_idx_n = '0;
    idle_cnt_n = (store || emit.vld || lane_idx == '0) ? '0 : idle_cnt + 1'b1;
  end

  // Emission select and lane write/clear strobes; a pending sop byte is already sitting in lane 0.
  always_comb begin
    emit    = '0;
    lane_wr = '0;
    clr_all = 1'b0;
    if (pend || realign) begin
      emit.vld   = 1'b1;
      emit.data  = lane_q;
      emit.be    = lane_v;
      clr_all    = 1'b1;
      lane_wr[0] = realign;
    end else if (store) begin
      if (last_lane || flush) begin
        emit.vld  = 1'b1;
        emit.data = cur_data;
        emit.be   = cur_mask;
        clr_all   = 1'b1;
      end else
        lane_wr[lane_idx] = 1'b1;
    end else if ((flush || expire) && lane_idx != '0) begin
      emit.vld  = 1'b1;
      emit.data = lane_q;
      emit.be   = lane_v;
      clr_all   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      out_q <= '0;
    else begin
      out_q.vld <= emit.vld;
      if (emit.vld) begin
        out_q.data <= emit.data;
        out_q.be   <= emit.be;
      end
    end
  end

  assign out_valid       = out_q.vld;
  assign out_data        = out_q.data;
  assign out_byte_enable = out_q.be;

`ifdef T2MI_PACKER_STATS_EN
  logic [31:0] words_q, partial_q, bytes_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q   <= '0;
      partial_q <= '0;
      bytes_q   <= '0;
    end else begin
      if (store)
        bytes_q <= bytes_q + 32'd1;
      if (emit.vld) begin
        words_q <= words_q + 32'd1;
        if (emit.be != '1)
          partial_q <= partial_q + 32'd1;
      end
    end
  end

  assign words_out     = words_q;
  assign partial_words = partial_q;
  assign bytes_in      = bytes_q;
`else
  assign words_out     = 32'd0;
  assign partial_words = 32'd0;
  assign bytes_in      = 32'd0;
`endif
endmodule
